// File: rtl/ones_pattern_pkg.sv
// Shared types, constants and helpers for the ones-pattern generator.
// States, LFSR definition and the request-count clamp live here.
package ones_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int          LfsrWidth   = 16;
    localparam logic [15:0] LfsrTaps    = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'hACE1;

    // Requests larger than the word saturate at the word width.
    function automatic logic [31:0] clamp_count(input logic [31:0] cnt,
                                                input logic [31:0] width);
        return (cnt > width) ? width : cnt;
    endfunction

endpackage

// File: rtl/rot_first_zero.sv
// Rotating priority finder: one-hot of the first zero bit at or below
// start, scanning downward and wrapping from bit 0 to bit Width-1.
module rot_first_zero
    import ones_pattern_pkg::*;
#(
    parameter int Width = 8,
    localparam int IdxW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] word,
    input  logic [IdxW-1:0]  start,
    output logic [Width-1:0] onehot,
    output logic             found
);

    logic [IdxW-1:0] idx;

    // Width is a power of two, so the index subtraction wraps for free.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < Width; k++) begin
            idx = start - IdxW'(k);
            if (!found && !word[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// Generates a Width-bit word with exactly min(req_cnt_i, Width) ones, one bit
// per cycle. Define ONES_PATTERN_RANDOM_EN for LFSR-chosen bit positions.
module ones_pattern_gen
    import ones_pattern_pkg::*;
#(
    parameter int          Width  = 8,
    parameter int          CntWdt = 16,
    parameter logic [15:0] Seed   = DefaultSeed
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [CntWdt-1:0] req_cnt_i,
    output logic [Width-1:0]  data_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              sat_o
);

    localparam int IdxW = (Width > 1) ? $clog2(Width) : 1;
    localparam int RemW = $clog2(Width + 1);
    localparam logic [LfsrWidth-1:0] SeedEff = (Seed == 16'h0000) ? 16'h0001 : Seed;

    state_e                 state, state_next;
    logic [Width-1:0]       data, data_next;
    logic                   sat, sat_next;
    logic [RemW-1:0]        remaining, remaining_next;
    logic [LfsrWidth-1:0]   lfsr, lfsr_next;
    logic [IdxW-1:0]        start;
    logic [Width-1:0]       onehot;
    logic                   found;
    logic [31:0]            n_full;

    assign n_full    = clamp_count(32'(req_cnt_i), 32'(Width));
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LfsrTaps) : (lfsr >> 1);

`ifdef ONES_PATTERN_RANDOM_EN
    assign start = lfsr[IdxW-1:0];
`else
    assign start = IdxW'(Width - 1);
`endif

    rot_first_zero #(
        .Width (Width)
    ) u_finder (
        .word   (data),
        .start  (start),
        .onehot (onehot),
        .found  (found)
    );

    // The LFSR free-runs out of reset so the pattern depends only on Seed
    // and request timing, not on which state the machine happens to be in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            data      <= '0;
            sat       <= 1'b0;
            remaining <= '0;
            lfsr      <= SeedEff;
        end else begin
            state     <= state_next;
            data      <= data_next;
            sat       <= sat_next;
            remaining <= remaining_next;
            lfsr      <= lfsr_next;
        end
    end

    always_comb begin
        state_next     = state;
        data_next      = data;
        sat_next       = sat;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    data_next      = '0;
                    sat_next       = 32'(req_cnt_i) > 32'(Width);
                    remaining_next = RemW'(n_full);
                    state_next     = (n_full == 32'd0) ? OUT : FILL;
                end
            end
            FILL: begin
                if (found) begin
                    data_next = data | onehot;
                end
                remaining_next = remaining - RemW'(1);
                if (remaining == RemW'(1)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (data_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready_o  = (state == IDLE);
    assign data_valid_o = (state == OUT);
    assign data_o       = data;
    assign sat_o        = sat;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen (Width=8); a cycle model derived
// from request count and latency rules is compared every cycle.
module tb_ones_pattern_gen;

    localparam int W = 8;
    localparam int NumBatch = 40;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [15:0]  req_cnt_i;
    logic [W-1:0] data_o;
    logic         data_valid_o;
    logic         data_ready_i;
    logic         sat_o;

    int checks = 0;
    int errors = 0;

    ones_pattern_gen #(
        .Width  (W),
        .CntWdt (16),
        .Seed   (16'hACE1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_cnt_i    (req_cnt_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .sat_o        (sat_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int count_ones(input logic [W-1:0] v);
        int c = 0;
        for (int i = 0; i < W; i++) c += int'(v[i]);
        return c;
    endfunction

    // MSB-first thermometer: 2^W - 2^(W-n).
    function automatic logic [W-1:0] thermo(input int n);
        if (n <= 0) return '0;
        return W'((1 << W) - (1 << (W - n)));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Model: a request of n ones is busy for n cycles, then the word waits
    // in the output slot until the consumer takes it.
    typedef enum {M_IDLE, M_WAIT, M_OUT} mmode_e;
    mmode_e       m_mode = M_IDLE;
    int           m_left = 0;
    int           m_n = 0;
    logic         m_sat = 1'b0;
    logic [W-1:0] m_word = '0;
    bit           m_en = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_mode = M_IDLE;
            m_word = '0;
            m_sat  = 1'b0;
            m_n    = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (req_valid_i) begin
                    m_n    = (int'(req_cnt_i) > W) ? W : int'(req_cnt_i);
                    m_sat  = int'(req_cnt_i) > W;
                    m_word = thermo(m_n);
                    if (m_n == 0) m_mode = M_OUT;
                    else begin
                        m_mode = M_WAIT;
                        m_left = m_n;
                    end
                end
                M_WAIT: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_OUT;
                end
                M_OUT: if (data_ready_i) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (m_en) begin
            checkOutput("req_ready", 32'(req_ready_o), 32'(m_mode == M_IDLE));
            checkOutput("data_valid", 32'(data_valid_o), 32'(m_mode == M_OUT));
            if (m_mode == M_OUT) begin
`ifdef ONES_PATTERN_RANDOM_EN
                checkOutput("popcount", 32'(count_ones(data_o)), 32'(m_n));
`else
                checkOutput("data", 32'(data_o), 32'(m_word));
`endif
                checkOutput("sat", 32'(sat_o), 32'(m_sat));
            end
        end
    end

    // Issue one request, measure latency, optionally stall the consumer
    // (poking req_valid meanwhile), then take the word.
    task automatic applyStimulus(input int cnt, input int hold, input bit poke,
                                 output logic [W-1:0] word, output logic sat,
                                 output int lat);
        bit got;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1;
        req_cnt_i   = 16'(cnt);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_cnt_i   = 16'h0055;
        got = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (data_valid_o) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        checkOutput("valid_timeout", 32'(got), 32'd1);
        word = data_o;
        sat  = sat_o;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            req_valid_i = poke;
            req_cnt_i   = 16'd7;
        end
        @(posedge clk_i); #1;
        req_valid_i  = 1'b0;
        data_ready_i = 1'b1;
        @(posedge clk_i); #1;
        data_ready_i = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    int           batch_cnt  [NumBatch];
    int           batch_hold [NumBatch];
    logic [W-1:0] batch_word [2][NumBatch];

    task automatic runBatch(input int pass);
        logic [W-1:0] w;
        logic         s;
        int           lat;
        pulseReset();
        for (int i = 0; i < NumBatch; i++) begin
            applyStimulus(batch_cnt[i], batch_hold[i], 1'b0, w, s, lat);
            batch_word[pass][i] = w;
            checkOutput("batch_latency", 32'(lat),
                        32'((batch_cnt[i] > W) ? W : batch_cnt[i]));
        end
    endtask

    initial begin
        logic [W-1:0] w;
        logic         s;
        int           lat;
        bit           got;

        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_cnt_i    = '0;
        data_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_valid", 32'(data_valid_o), 32'd0);
        checkOutput("reset_data", 32'(data_o), 32'd0);
        checkOutput("reset_sat", 32'(sat_o), 32'd0);
        m_en = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        $display("[TB] basic counts");
        applyStimulus(3, 0, 1'b0, w, s, lat);
        checkOutput("cnt3_latency", 32'(lat), 32'd3);
        checkOutput("cnt3_sat", 32'(s), 32'd0);
`ifndef ONES_PATTERN_RANDOM_EN
        checkOutput("cnt3_word", 32'(w), 32'h0000_00E0);
        checkOutput("model_thermo3", 32'(thermo(3)), 32'h0000_00E0);
`endif
        applyStimulus(0, 0, 1'b0, w, s, lat);
        checkOutput("cnt0_latency", 32'(lat), 32'd0);
        checkOutput("cnt0_word", 32'(w), 32'd0);
        checkOutput("cnt0_sat", 32'(s), 32'd0);
        applyStimulus(20, 0, 1'b0, w, s, lat);
        checkOutput("cnt20_latency", 32'(lat), 32'd8);
        checkOutput("cnt20_word", 32'(w), 32'h0000_00FF);
        checkOutput("cnt20_sat", 32'(s), 32'd1);

        $display("[TB] consumer stall with request poking");
        applyStimulus(4, 5, 1'b1, w, s, lat);
        checkOutput("stall_latency", 32'(lat), 32'd4);
        checkOutput("stall_popcount", 32'(count_ones(w)), 32'd4);

        $display("[TB] ready held before valid");
        @(posedge clk_i); #1;
        data_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_cnt_i    = 16'd5;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (data_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("preready_timeout", 32'(got), 32'd1);
        checkOutput("preready_popcount", 32'(count_ones(data_o)), 32'd5);
        @(posedge clk_i); #1;
        data_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("preready_idle", 32'(req_ready_o), 32'd1);

        $display("[TB] reset during fill");
        @(posedge clk_i); #1;
        req_valid_i = 1'b1;
        req_cnt_i   = 16'd6;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_valid", 32'(data_valid_o), 32'd0);
        checkOutput("abort_data", 32'(data_o), 32'd0);
        checkOutput("abort_ready", 32'(req_ready_o), 32'd1);
        applyStimulus(2, 0, 1'b0, w, s, lat);
        checkOutput("after_abort_latency", 32'(lat), 32'd2);
`ifndef ONES_PATTERN_RANDOM_EN
        checkOutput("after_abort_word", 32'(w), 32'h0000_00C0);
`else
        checkOutput("after_abort_popcount", 32'(count_ones(w)), 32'd2);
`endif

        $display("[TB] batch and rerun");
        for (int i = 0; i < NumBatch; i++) begin
            batch_cnt[i]  = int'($urandom_range(0, 10));
            batch_hold[i] = int'($urandom_range(0, 2));
        end
        runBatch(0);
        runBatch(1);
        for (int i = 0; i < NumBatch; i++) begin
            checkOutput("rerun_word", 32'(batch_word[1][i]), 32'(batch_word[0][i]));
        end

        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
